// File: rtl/dmem_bus_responder.sv
// dmem_bus_responder: data-memory responder (word RAM + DISP/TCNT/TDIV/LED/SW I/O); SW_SYNC_EN adds a 2-flop switch synchronizer
module dmem_bus_responder #(
  parameter int          RAM_AW  = 14,
  parameter logic [31:0] IO_BASE = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  input  logic [23:0] sw_in,
  output logic [23:0] led_out,
  output logic [31:0] disp_out
);
  localparam logic [31:0] A_DISP = IO_BASE;
  localparam logic [31:0] A_TCNT = IO_BASE + 32'h20;
  localparam logic [31:0] A_TDIV = IO_BASE + 32'h24;
  localparam logic [31:0] A_LED  = IO_BASE + 32'h60;
  localparam logic [31:0] A_SW   = IO_BASE + 32'h70;

  logic [31:0] ram [2**RAM_AW];
  logic [31:0] disp_q, disp_d, tcnt_q, tcnt_d, tdiv_q, tdiv_d, pcnt_q, pcnt_d;
  logic [23:0] led_q, led_d, sw_val;
  logic [29:0] wa;
  logic        is_ram, is_disp, is_tcnt, is_tdiv, is_led, is_sw, tick;
  logic [RAM_AW-1:0] idx;
  logic        unused;

  assign unused  = ^cpu_addr[1:0];
  assign wa      = cpu_addr[31:2];
  assign idx     = cpu_addr[RAM_AW+1:2];
  assign is_ram  = cpu_addr[31:RAM_AW+2] == '0;
  assign is_disp = wa == A_DISP[31:2];
  assign is_tcnt = wa == A_TCNT[31:2];
  assign is_tdiv = wa == A_TDIV[31:2];
  assign is_led  = wa == A_LED[31:2];
  assign is_sw   = wa == A_SW[31:2];
  assign led_out  = led_q;
  assign disp_out = disp_q;

`ifdef SW_SYNC_EN
  logic [23:0] sw_s1_q, sw_s2_q;
  // two-flop synchronizer for the asynchronous board switches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw_in;
      sw_s2_q <= sw_s1_q;
    end
  end
  assign sw_val = sw_s2_q;
`else
  assign sw_val = sw_in;
`endif

  // combinational load mux; current state only, so same-cycle writes are not visible
  always_comb begin
    cpu_rdata = is_ram  ? ram[idx] :
                is_disp ? disp_q :
                is_tcnt ? tcnt_q :
                is_tdiv ? tdiv_q :
                is_led  ? {8'h00, led_q} :
                is_sw   ? {8'h00, sw_val} : 32'h0;
  end

  // next state: register writes, prescaler and timer (a TCNT store beats a tick)
  always_comb begin
    tick   = pcnt_q == tdiv_q;
    pcnt_d = (tick || (cpu_we && is_tdiv)) ? 32'h0 : pcnt_q + 32'd1;
    tcnt_d = (cpu_we && is_tcnt) ? cpu_wdata : tick ? tcnt_q + 32'd1 : tcnt_q;
    tdiv_d = (cpu_we && is_tdiv) ? cpu_wdata : tdiv_q;
    disp_d = (cpu_we && is_disp) ? cpu_wdata : disp_q;
    led_d  = (cpu_we && is_led) ? cpu_wdata[23:0] : led_q;
  end

  // I/O and timer state, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
      led_q  <= '0;
      tcnt_q <= '0;
      tdiv_q <= '0;
      pcnt_q <= '0;
    end else begin
      disp_q <= disp_d;
      led_q  <= led_d;
      tcnt_q <= tcnt_d;
      tdiv_q <= tdiv_d;
      pcnt_q <= pcnt_d;
    end
  end

  // word RAM, never reset; stores are dropped while reset is asserted
  always_ff @(posedge clk) begin
    if (rst_n && cpu_we && is_ram) ram[idx] <= cpu_wdata;
  end
endmodule

// File: tb/tb_dmem_bus_responder.sv
// tb_dmem_bus_responder: directed self-checking bench for dmem_bus_responder
module tb_dmem_bus_responder;
  localparam logic [31:0] IO = 32'hFFFF_F000;
  logic        clk = 1'b0, rst_n = 1'b1, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata, disp_out;
  logic [23:0] sw_in = '0, led_out;
  int          n_chk = 0, n_pass = 0;

  dmem_bus_responder dut (
    .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .sw_in(sw_in),
    .led_out(led_out), .disp_out(disp_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    cpu_we = 1'b0;
    cpu_addr = a;
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    cpu_we = 1'b1;
    cpu_addr = a;
    cpu_wdata = d;
    step();
    cpu_we = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    rd(IO + 32'h00); chk("rst_disp", cpu_rdata, 32'h0);
    rd(IO + 32'h20); chk("rst_tcnt", cpu_rdata, 32'h0);
    rd(IO + 32'h24); chk("rst_tdiv", cpu_rdata, 32'h0);
    rd(IO + 32'h60); chk("rst_led", cpu_rdata, 32'h0);
    chk("rst_led_out", {8'h0, led_out}, 32'h0);
    chk("rst_disp_out", disp_out, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    // RAM store/load, read-during-write returns old data
    st(32'h10, 32'h1111_1111);
    cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF; #1;
    chk("ram_rdw_old", cpu_rdata, 32'h1111_1111);
    step();
    rd(32'h10); chk("ram_rd", cpu_rdata, 32'hDEAD_BEEF);
    rd(32'h13); chk("ram_rd_lowbits", cpu_rdata, 32'hDEAD_BEEF);
    // addresses at the region top are not RAM and do not alias word 0
    st(32'h0, 32'h0000_AAAA);
    st(32'h0001_0000, 32'h0000_5555);
    rd(32'h0); chk("ram_no_wrap", cpu_rdata, 32'h0000_AAAA);
    rd(32'h0001_0000); chk("above_ram_rd", cpu_rdata, 32'h0);
    // LED and DISP
    cpu_we = 1'b1; cpu_addr = IO + 32'h60; cpu_wdata = 32'h1234_5678; #1;
    chk("led_before_edge", {8'h0, led_out}, 32'h0);
    step(); cpu_we = 1'b0;
    chk("led_out", {8'h0, led_out}, 32'h0034_5678);
    rd(IO + 32'h60); chk("led_rd", cpu_rdata, 32'h0034_5678);
    st(IO + 32'h00, 32'hCAFE_F00D);
    chk("disp_out", disp_out, 32'hCAFE_F00D);
    rd(IO + 32'h00); chk("disp_rd", cpu_rdata, 32'hCAFE_F00D);
    // timer with TDIV=3: TCNT cleared one edge after the TDIV store
    st(IO + 32'h24, 32'd3);
    st(IO + 32'h20, 32'd0);
    rd(IO + 32'h24); chk("tdiv_rd", cpu_rdata, 32'd3);
    step(); step();
    rd(IO + 32'h20); chk("tcnt_3cyc", cpu_rdata, 32'd0);
    step();
    rd(IO + 32'h20); chk("tcnt_4cyc", cpu_rdata, 32'd1);
    step(); step(); step();
    rd(IO + 32'h20); chk("tcnt_7cyc", cpu_rdata, 32'd1);
    step();
    rd(IO + 32'h20); chk("tcnt_8cyc", cpu_rdata, 32'd2);
    // TDIV=0 and wrap
    st(IO + 32'h24, 32'd0);
    st(IO + 32'h20, 32'hFFFF_FFFF);
    rd(IO + 32'h20); chk("tcnt_load_max", cpu_rdata, 32'hFFFF_FFFF);
    step();
    rd(IO + 32'h20); chk("tcnt_wrap", cpu_rdata, 32'h0);
    // TCNT store beats a simultaneous tick
    st(IO + 32'h20, 32'd100);
    rd(IO + 32'h20); chk("tcnt_write_wins", cpu_rdata, 32'd100);
    step();
    rd(IO + 32'h20); chk("tcnt_after_write", cpu_rdata, 32'd101);
    // switches
    sw_in = 24'hAB_CDEF;
    rd(IO + 32'h70);
`ifdef SW_SYNC_EN
    chk("sw_sync_0", cpu_rdata, 32'h0);
    step(); rd(IO + 32'h70);
    chk("sw_sync_1", cpu_rdata, 32'h0);
    step(); rd(IO + 32'h70);
    chk("sw_sync_2", cpu_rdata, 32'h00AB_CDEF);
`else
    chk("sw_direct", cpu_rdata, 32'h00AB_CDEF);
`endif
    // stores to SW and unmapped offsets are dropped
    st(IO + 32'h70, 32'h1234_5678);
    rd(IO + 32'h70); chk("sw_ro", cpu_rdata, 32'h00AB_CDEF);
    st(IO + 32'h40, 32'h7777_7777);
    rd(IO + 32'h40); chk("unmapped_rd", cpu_rdata, 32'h0);
    chk("unmapped_disp", disp_out, 32'hCAFE_F00D);
    chk("unmapped_led", {8'h0, led_out}, 32'h0034_5678);
    // asynchronous reset in the middle of an LED store
    cpu_we = 1'b1; cpu_addr = IO + 32'h60; cpu_wdata = 32'h00FF_FFFF; #2;
    rst_n = 1'b0; #1;
    chk("rst_async_led", {8'h0, led_out}, 32'h0);
    chk("rst_async_disp", disp_out, 32'h0);
    step();
    chk("rst_store_dropped", {8'h0, led_out}, 32'h0);
    rd(IO + 32'h70);
`ifdef SW_SYNC_EN
    chk("rst_sw_rd", cpu_rdata, 32'h0);
`else
    chk("rst_sw_rd", cpu_rdata, 32'h00AB_CDEF);
`endif
    rd(32'h10); chk("rst_ram_kept", cpu_rdata, 32'hDEAD_BEEF);
    rst_n = 1'b1;
    step();
    chk("post_rst_led", {8'h0, led_out}, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
